// File: rtl/dram_sched_pkg.sv
// Shared types for the DRAM request scheduler buffer.
// Request entry layout, address decode and refresh FSM states.
package dram_sched_pkg;

    typedef struct packed {
        logic [2:0]  rank;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [17:0] row;
        logic [13:0] col;
        logic        wen;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic {
        R_IDLE,
        R_REQ
    } refresh_state_t;

    function automatic logic [31:0] field_mask(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // Address map MSB->LSB: {rank, row, bg, ba, col, 2'b00}
    function automatic req_t decode_addr(
        input logic [31:0] addr,
        input int          col_bits,
        input int          ba_bits,
        input int          bg_bits,
        input int          row_bits,
        input int          rank_bits
    );
        req_t        d;
        logic [31:0] a;
        d = '0;
        a = addr >> 2;
        d.col  = 14'(a & field_mask(col_bits));
        a = a >> col_bits;
        d.ba   = 2'(a & field_mask(ba_bits));
        a = a >> ba_bits;
        d.bg   = 2'(a & field_mask(bg_bits));
        a = a >> bg_bits;
        d.row  = 18'(a & field_mask(row_bits));
        a = a >> row_bits;
        d.rank = 3'(a & field_mask(rank_bits));
        return d;
    endfunction

endpackage

// File: rtl/dram_request_scheduler_buffer_timer.sv
// Refresh interval timer with postponed-refresh debt tracking.
// Debt saturates at MAX_DEBT; a further expiry sets the sticky overflow.
module dram_refresh_timer #(
    parameter int TREFI    = 6240,
    parameter int MAX_DEBT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic debt_dec,
    output logic expire,
    output logic debt_nz,
    output logic debt_multi,
    output logic overflow
);

    localparam int TW = $clog2(TREFI + 1);
    localparam int DW = $clog2(MAX_DEBT + 1);
    localparam int SW = DW + 1;

    logic [TW-1:0] timer_q;
    logic [DW-1:0] debt_q;
    logic [DW-1:0] debt_d;
    logic          ovf_set;
    logic          dec;
    logic [SW-1:0] sum;

    assign expire     = (timer_q == '0);
    assign debt_nz    = (debt_q != '0);
    assign debt_multi = (debt_q > DW'(1));
    assign dec        = debt_dec && debt_nz;

    always_comb begin
        debt_d  = debt_q;
        ovf_set = 1'b0;
        sum     = {1'b0, debt_q} + SW'(expire) - SW'(dec);
        if (sum > SW'(MAX_DEBT)) begin
            debt_d  = DW'(MAX_DEBT);
            ovf_set = 1'b1;
        end else begin
            debt_d  = sum[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= TW'(TREFI - 1);
            debt_q   <= '0;
            overflow <= 1'b0;
        end else begin
            timer_q  <= expire ? TW'(TREFI - 1) : timer_q - TW'(1);
            debt_q   <= debt_d;
            overflow <= overflow | ovf_set;
        end
    end

endmodule

// File: rtl/dram_request_scheduler_buffer.sv
// In-order request queue feeding the DRAM command generator.
// Exposes head (curr) and head+1 (ftr) and arbitrates refresh.
module dram_request_scheduler_buffer
    import dram_sched_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int COL_BITS  = 10,
    parameter int BA_BITS   = 2,
    parameter int BG_BITS   = 2,
    parameter int ROW_BITS  = 15,
    parameter int RANK_BITS = 1,
    parameter int TREFI     = 6240,
    parameter int MAX_DEBT  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_write,
    output logic [31:0] resp_rdata,
    output logic [2:0]  Ra0,
    output logic [2:0]  Ra1,
    output logic [1:0]  BG0,
    output logic [1:0]  BG1,
    output logic [1:0]  BA0,
    output logic [1:0]  BA1,
    output logic [17:0] R0,
    output logic [17:0] R1,
    output logic [13:0] COL0,
    output logic [13:0] COL1,
    output logic        dREN_curr,
    output logic        dWEN_curr,
    output logic        dREN_ftr,
    output logic        dWEN_ftr,
    output logic [31:0] write_data,
    output logic        REFRESH,
    input  logic        request_done,
    input  logic [31:0] data_callback,
    output logic        refresh_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_t           mem [DEPTH];
    req_t           new_req;
    req_t           curr;
    req_t           ftr;
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;
    logic           full;
    logic           empty;
    logic           has_ftr;
    logic           push;
    logic           pop;
    refresh_state_t state_q;
    refresh_state_t state_d;
    logic           refreshing;
    logic           expire;
    logic           debt_nz;
    logic           debt_multi;
    logic           debt_dec;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign has_ftr    = (count_q >= CW'(2));
    assign refreshing = (state_q == R_REQ);
    assign push       = req_valid && !full;
    assign pop        = request_done && !refreshing && !empty;
    assign req_ready  = !full;

    always_comb begin
        new_req = decode_addr(req_addr, COL_BITS, BA_BITS,
                              BG_BITS, ROW_BITS, RANK_BITS);
        new_req.wen   = req_wen;
        new_req.wdata = req_wdata;
    end

    always_ff @(posedge CLK) begin
        if (push) mem[tail_q] <= new_req;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Absent slots read as all-zero so every field output is 0.
    always_comb begin
        curr = '0;
        ftr  = '0;
        if (!empty) curr = mem[head_q];
        if (has_ftr) ftr = mem[head_q + PW'(1)];
    end

    assign Ra0        = curr.rank;
    assign Ra1        = ftr.rank;
    assign BG0        = curr.bg;
    assign BG1        = ftr.bg;
    assign BA0        = curr.ba;
    assign BA1        = ftr.ba;
    assign R0         = curr.row;
    assign R1         = ftr.row;
    assign COL0       = curr.col;
    assign COL1       = ftr.col;
    assign write_data = curr.wdata;
    assign dREN_curr  = !empty && !curr.wen && !refreshing;
    assign dWEN_curr  = !empty && curr.wen && !refreshing;
    assign dREN_ftr   = has_ftr && !ftr.wen && !refreshing;
    assign dWEN_ftr   = has_ftr && ftr.wen && !refreshing;
    assign REFRESH    = refreshing;

    always_ff @(posedge CLK) begin
        if (RST) begin
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= pop;
            resp_write <= pop && curr.wen;
            resp_rdata <= (pop && !curr.wen) ? data_callback : '0;
        end
    end

    // Refresh only starts at a request boundary; a same-cycle expiry counts.
    always_comb begin
        state_d  = state_q;
        debt_dec = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if ((debt_nz || expire) && (empty || pop)) state_d = R_REQ;
            end
            R_REQ: begin
                if (request_done) begin
                    debt_dec = 1'b1;
                    if (!debt_multi && !expire) state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= R_IDLE;
        else     state_q <= state_d;
    end

    dram_refresh_timer #(
        .TREFI    (TREFI),
        .MAX_DEBT (MAX_DEBT)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .debt_dec   (debt_dec),
        .expire     (expire),
        .debt_nz    (debt_nz),
        .debt_multi (debt_multi),
        .overflow   (refresh_overflow)
    );

endmodule

// File: tb/tb_dram_request_scheduler_buffer.sv
// Randomized bench for dram_request_scheduler_buffer against a
// queue-based reference model of the scheduler rules.
module tb_dram_request_scheduler_buffer;

    localparam int DEPTH = 8;
    localparam int TREFI = 16;
    localparam int MAXD  = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_write;
    logic [31:0] resp_rdata;
    logic [2:0]  Ra0, Ra1;
    logic [1:0]  BG0, BG1, BA0, BA1;
    logic [17:0] R0, R1;
    logic [13:0] COL0, COL1;
    logic        dREN_curr, dWEN_curr, dREN_ftr, dWEN_ftr;
    logic [31:0] write_data;
    logic        REFRESH;
    logic        request_done = 1'b0;
    logic [31:0] data_callback = '0;
    logic        refresh_overflow;

    always #5 CLK = ~CLK;

    dram_request_scheduler_buffer #(
        .DEPTH (DEPTH), .TREFI (TREFI), .MAX_DEBT (MAXD)
    ) dut (
        .CLK (CLK), .RST (RST),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_addr (req_addr), .req_wen (req_wen), .req_wdata (req_wdata),
        .resp_valid (resp_valid), .resp_write (resp_write),
        .resp_rdata (resp_rdata),
        .Ra0 (Ra0), .Ra1 (Ra1), .BG0 (BG0), .BG1 (BG1),
        .BA0 (BA0), .BA1 (BA1), .R0 (R0), .R1 (R1),
        .COL0 (COL0), .COL1 (COL1),
        .dREN_curr (dREN_curr), .dWEN_curr (dWEN_curr),
        .dREN_ftr (dREN_ftr), .dWEN_ftr (dWEN_ftr),
        .write_data (write_data), .REFRESH (REFRESH),
        .request_done (request_done), .data_callback (data_callback),
        .refresh_overflow (refresh_overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
    } ment_t;

    ment_t       mq[$];
    int          m_tmr;
    int          m_debt;
    bit          m_refr;
    bit          m_ovf;
    bit          m_rv;
    bit          m_rw;
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {rank3, bg2, ba2, row18, col14} from the byte address map
    function automatic logic [38:0] fields(input logic [31:0] a);
        return {2'b00, a[31], a[15:14], a[13:12],
                3'b000, a[30:16], 4'b0000, a[11:2]};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tmr  = TREFI - 1;
        m_debt = 0;
        m_refr = 0;
        m_ovf  = 0;
        m_rv   = 0;
        m_rw   = 0;
        m_rd   = '0;
    endtask

    task automatic check_outputs();
        logic [38:0] ce, fe;
        logic [3:0]  ve;
        logic [31:0] wd;
        ce = '0; fe = '0; ve = '0; wd = '0;
        if (mq.size() >= 1) begin
            ce = fields(mq[0].addr);
            wd = mq[0].wdata;
            if (!m_refr) ve[3:2] = {!mq[0].wen, mq[0].wen};
        end
        if (mq.size() >= 2) begin
            fe = fields(mq[1].addr);
            if (!m_refr) ve[1:0] = {!mq[1].wen, mq[1].wen};
        end
        chk("curr", 64'({Ra0, BG0, BA0, R0, COL0}), 64'(ce));
        chk("ftr", 64'({Ra1, BG1, BA1, R1, COL1}), 64'(fe));
        chk("valids", 64'({dREN_curr, dWEN_curr, dREN_ftr, dWEN_ftr}),
            64'(ve));
        chk("wdata", 64'(write_data), 64'(wd));
        chk("ready", 64'(req_ready), 64'(mq.size() < DEPTH));
        chk("refresh", 64'(REFRESH), 64'(m_refr));
        chk("resp", 64'({resp_valid, resp_write, resp_rdata}),
            64'({m_rv, m_rw, m_rd}));
        chk("overflow", 64'(refresh_overflow), 64'(m_ovf));
    endtask

    task automatic model_step(input bit v, input bit w,
                              input logic [31:0] a, input logic [31:0] wd,
                              input bit done, input logic [31:0] cb);
        bit    empty, ready, ex, pop, dec, nr;
        int    d;
        ment_t h;
        empty = (mq.size() == 0);
        ready = (mq.size() < DEPTH);
        ex    = (m_tmr == 0);
        pop   = done && !m_refr && !empty;
        dec   = done && m_refr && (m_debt > 0);
        if (!m_refr) nr = (m_debt > 0 || ex) && (empty || pop);
        else         nr = !(done && (m_debt - 1 + int'(ex)) <= 0);
        d = m_debt + int'(ex) - int'(dec);
        if (d > MAXD) begin
            d     = MAXD;
            m_ovf = 1;
        end
        m_rv = pop;
        m_rw = 0;
        m_rd = '0;
        if (pop) begin
            h    = mq.pop_front();
            m_rw = h.wen;
            m_rd = h.wen ? 32'h0 : cb;
        end
        if (v && ready) mq.push_back('{addr: a, wen: w, wdata: wd});
        m_tmr  = ex ? TREFI - 1 : m_tmr - 1;
        m_debt = d;
        m_refr = nr;
    endtask

    task automatic cycle(input bit v, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input bit done,
                         input logic [31:0] cb);
        @(negedge CLK);
        req_valid     = v;
        req_wen       = w;
        req_addr      = a;
        req_wdata     = wd;
        request_done  = done;
        data_callback = cb;
        #1;
        check_outputs();
        model_step(v, w, a, wd, done, cb);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RST          = 1'b1;
        req_valid    = 1'b0;
        request_done = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic rnd(input int n, input int p_push, input int p_done);
        repeat (n) begin
            cycle($urandom_range(99) < p_push, 1'($urandom_range(1)),
                  $urandom, $urandom,
                  $urandom_range(99) < p_done, $urandom);
        end
    endtask

    initial begin
        model_reset();
        do_reset(3);

        cycle(1, 0, 32'h0001_2344, 32'h0, 0, 32'h0);
        cycle(0, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("col0_dir", 64'(COL0), 64'h0D1);
        chk("dren_dir", 64'(dREN_curr), 64'h1);

        do_reset(1);
        for (int i = 0; i < 9; i++)
            cycle(1, 1, 32'h1000 * i, 32'hA000_0000 + i, 0, 32'h0);
        chk("full_ready", 64'(req_ready), 64'h0);
        cycle(1, 1, 32'h9000, 32'hA000_0008, 1, 32'h0);
        cycle(0, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("wr_resp", 64'({resp_valid, resp_write}), 64'h3);

        do_reset(1);
        cycle(1, 0, 32'h8765_4320, 32'h0, 0, 32'h0);
        cycle(1, 0, 32'h0123_4568, 32'h0, 0, 32'h0);
        cycle(0, 0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF);
        cycle(0, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("rd_resp", 64'(resp_rdata), 64'hDEAD_BEEF);

        do_reset(1);
        rnd(40, 0, 0);
        rnd(40, 0, 30);

        do_reset(1);
        cycle(1, 1, 32'h00AB_CD00, 32'h5555_AAAA, 0, 32'h0);
        rnd(40, 60, 0);
        rnd(60, 20, 40);

        rnd(600, 50, 30);

        rnd(170, 20, 0);
        chk("ovf_dir", 64'(refresh_overflow), 64'h1);
        rnd(100, 40, 50);

        rnd(30, 70, 10);
        do_reset(1);
        cycle(0, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("rst_ready", 64'(req_ready), 64'h1);
        rnd(200, 50, 35);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
